// File: rtl/npcg_toggle_bcmd_manager_wd.sv
// Blocking-command manager: gates command issue while a multi-step command owns the bus, with bus high-Z turnaround, abort and watchdog.
// Latency: state and way/blocking flags register on the start edge; the valid/ready/POE outputs are combinational from the registered blocking flag.
// Backpressure: while blocking, oCMDValid_out and oCMDReady_out are forced low; iCMDHold also gates them while not blocking.
module npcg_toggle_bcmd_manager_wd #(
  parameter int unsigned             NumberOfWays  = 4,
  parameter int unsigned             BusHiZDelay   = 4,
  parameter int unsigned             TimeoutWidth  = 16,
  parameter logic [TimeoutWidth-1:0] TimeoutCycles = 16'd4096,
  parameter logic [5:0]              POEOpcode     = 6'b111110,
  parameter logic [4:0]              POEID         = 5'b00101
) (
  input  logic                    iSystemClock,
  input  logic                    iReset,
  input  logic [NumberOfWays-1:0] iTargetWay,
  input  logic                    ibCMDStart,
  input  logic                    ibCMDLast,
  input  logic                    ibCMDLast_SCC,
  input  logic                    ibCMDAbort,
  input  logic                    iNANDPOE,
  input  logic                    iCMDHold,
  input  logic [5:0]              iOpcode,
  input  logic [4:0]              iTargetID,
  input  logic [4:0]              iSourceID,
  input  logic                    iCMDValid_in,
  input  logic                    iCMDReady_in,
  output logic [5:0]              oOpcode_out,
  output logic [4:0]              oTargetID_out,
  output logic [4:0]              oSourceID_out,
  output logic                    oCMDValid_out_NPOE,
  output logic                    oCMDValid_out,
  output logic                    oCMDReady_out,
  output logic [NumberOfWays-1:0] oWorkingWay,
  output logic                    oBlocking,
  output logic                    oTimeout,
  output logic                    oStartReject
);

  typedef enum logic [4:0] {
    ST_RESET = 5'b00001,
    ST_READY = 5'b00010,
    ST_START = 5'b00100,
    ST_RUNNG = 5'b01000,
    ST_BHZD  = 5'b10000
  } state_t;

  localparam logic [3:0] HzLimit = 4'(BusHiZDelay);

  state_t                  state_q, state_d;
  logic                    blk_q, blk_d;
  logic [NumberOfWays-1:0] way_q, way_d;
  logic [TimeoutWidth-1:0] wdog_q, wdog_d;
  logic [3:0]              hz_q, hz_d;
  logic                    to_q, to_d;
  logic                    rej_q, rej_d;

  logic                    wd_expired;
  logic                    start_accept;
  logic                    start_reject;
  logic                    wd_fire;

  // A zero limit disables the watchdog entirely.
  assign wd_expired = (TimeoutCycles != '0) && (wdog_q == TimeoutCycles);

  // Next-state selection; last beats abort beats watchdog when leaving START/RUNNG.
  always_comb begin
    state_d      = state_q;
    start_accept = 1'b0;
    start_reject = 1'b0;
    wd_fire      = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_READY;
      ST_READY: begin
        if (ibCMDStart) begin
          if (iTargetWay != '0) begin
            state_d      = ST_START;
            start_accept = 1'b1;
          end else begin
            start_reject = 1'b1;
          end
        end
      end
      ST_START, ST_RUNNG: begin
        if (ibCMDLast && ibCMDLast_SCC) begin
          state_d = ST_READY;
        end else if (ibCMDLast) begin
          state_d = ST_BHZD;
        end else if (ibCMDAbort) begin
          state_d = ST_BHZD;
        end else if (wd_expired) begin
          state_d = ST_BHZD;
          wd_fire = 1'b1;
        end else begin
          state_d = ST_RUNNG;
        end
      end
      ST_BHZD: begin
        if (hz_q == HzLimit) state_d = ST_READY;
      end
      default: state_d = ST_READY;
    endcase
  end

  // Datapath actions keyed off the state being entered so flags line up with the transition edge.
  always_comb begin
    blk_d  = blk_q;
    way_d  = way_q;
    wdog_d = wdog_q;
    hz_d   = hz_q;
    case (state_d)
      ST_START: begin
        blk_d  = 1'b1;
        way_d  = iTargetWay;
        wdog_d = TimeoutWidth'(1);
        hz_d   = 4'd0;
      end
      ST_RUNNG: begin
        blk_d = 1'b1;
        if (TimeoutCycles != '0) begin
          if (wdog_q != TimeoutCycles) wdog_d = wdog_q + TimeoutWidth'(1);
        end else if (wdog_q != '1) begin
          wdog_d = wdog_q + TimeoutWidth'(1);
        end
      end
      ST_BHZD: begin
        blk_d  = 1'b1;
        hz_d   = hz_q + 4'd1;
        wdog_d = '0;
      end
      default: begin
        blk_d  = 1'b0;
        way_d  = '0;
        wdog_d = '0;
        hz_d   = 4'd0;
      end
    endcase
  end

  // Sticky timeout: set on watchdog exit, cleared only by a new accepted start or reset.
  always_comb begin
    to_d = to_q;
    if (start_accept) to_d = 1'b0;
    if (wd_fire)      to_d = 1'b1;
    rej_d = start_reject;
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge iSystemClock or posedge iReset) begin
    if (iReset) begin
      state_q <= ST_RESET;
      blk_q   <= 1'b0;
      way_q   <= '0;
      wdog_q  <= '0;
      hz_q    <= 4'd0;
      to_q    <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      way_q   <= way_d;
      wdog_q  <= wdog_d;
      hz_q    <= hz_d;
      to_q    <= to_d;
      rej_q   <= rej_d;
    end
  end

  // POE override ignores the FSM; only valid/ready are gated by blocking.
  assign oOpcode_out        = iNANDPOE ? POEOpcode : iOpcode;
  assign oTargetID_out      = iNANDPOE ? POEID : iTargetID;
  assign oSourceID_out      = iNANDPOE ? POEID : iSourceID;
  assign oCMDValid_out_NPOE = ~blk_q & (iNANDPOE | iCMDValid_in);
  assign oCMDValid_out      = ~blk_q & ~iCMDHold & iCMDValid_in & ~iNANDPOE;
  assign oCMDReady_out      = ~blk_q & ~iCMDHold & iCMDReady_in & ~iNANDPOE;
  assign oWorkingWay        = way_q;
  assign oBlocking          = blk_q;
  assign oTimeout           = to_q;
  assign oStartReject       = rej_q;

endmodule
